pr3_frame_decoder: RTL and testbench

Receive-side counterpart of PR3: consumes PR3's 32-bit `source_valid`/`source_data` spectrum stream on `clk40` and parses it into per-bin records tagged with channel and bin index. Validates framing, per-channel sequence numbers and the frame checksum, and flags each completed frame as good or bad. Sits downstream of PR3, ahead of the spectrum store/readout logic.

---
 rtl/pr3_pkg.sv | 18 +
 rtl/pr3_seq_tracker.sv | 32 +++
 rtl/pr3_frame_decoder.sv | 145 ++++++++++++++
 tb/tb_pr3_frame_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pr3_pkg.sv
// Shared definitions for the PR3 spectrum stream: header layout, sync byte
// and the receive-side framing state encoding.
package pr3_pkg;

    localparam logic [7:0] PR3_SYNC = 8'hA5;

    // Header word = {sync[31:24], channel[23:16], seq[15:0]}
    localparam int HDR_SYNC_LSB = 24;
    localparam int HDR_CHAN_LSB = 16;
    localparam int HDR_SEQ_LSB  = 0;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        TRAILER = 2'd2
    } pr3_dec_state_t;

endpackage

// File: rtl/pr3_seq_tracker.sv
// Per-channel sequence tracker: remembers the last seq seen on each channel
// and flags a gap when a new frame does not follow it by exactly one.
module pr3_seq_tracker #(
    parameter int NSINK = 3
) (
    input  logic                     clk40,
    input  logic                     reset,
    input  logic [$clog2(NSINK)-1:0] chan_i,
    input  logic [15:0]              seq_i,
    input  logic                     upd_i,
    output logic                     seq_err_o
);

    logic [15:0] last_q [NSINK];
    logic        seen_q [NSINK];

    // The first frame on a channel has nothing to compare against, so it passes.
    assign seq_err_o = seen_q[chan_i] && (seq_i != last_q[chan_i] + 16'd1);

    always_ff @(posedge clk40) begin
        if (reset) begin
            for (int i = 0; i < NSINK; i++) begin
                last_q[i] <= '0;
                seen_q[i] <= 1'b0;
            end
        end else if (upd_i) begin
            last_q[chan_i] <= seq_i;
            seen_q[chan_i] <= 1'b1;
        end
    end

endmodule

// File: rtl/pr3_frame_decoder.sv
// Parses the PR3 spectrum stream into per-bin records and reports, once the
// trailer arrives, whether the frame's sequence number and checksum were good.
module pr3_frame_decoder
    import pr3_pkg::*;
#(
    parameter int NSINK = 3,
    parameter int FFT   = 11
) (
    input  logic                     clk40,
    input  logic                     reset,
    input  logic                     sink_valid,
    input  logic [31:0]              sink_data,
    output logic                     source_valid,
    output logic [$clog2(NSINK)-1:0] source_channel,
    output logic [FFT-2:0]           source_bin,
    output logic [31:0]              source_data,
    output logic                     frame_done,
    output logic                     frame_ok,
    output logic                     err_sync,
    output logic                     err_seq,
    output logic                     err_csum
);

    localparam int CHW = $clog2(NSINK);
    localparam logic [7:0]     NSINK_B  = 8'(NSINK);
    localparam logic [FFT-2:0] LAST_BIN = '1;

    pr3_dec_state_t state_q, state_d;
    logic [FFT-2:0] cnt_q, cnt_d;
    logic [31:0]    acc_q, acc_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [15:0]    seq_q, seq_d;

    logic           rec_valid_d, done_d, ok_d, sync_d, eseq_d, ecsum_d;
    logic [CHW-1:0] rec_ch_d;
    logic [FFT-2:0] rec_bin_d;
    logic [31:0]    rec_data_d;

    logic trk_upd, trk_err;
    logic [7:0] hdr_sync, hdr_chan;

    assign hdr_sync = sink_data[HDR_SYNC_LSB +: 8];
    assign hdr_chan = sink_data[HDR_CHAN_LSB +: 8];

    pr3_seq_tracker #(.NSINK(NSINK)) u_seq (
        .clk40     (clk40),
        .reset     (reset),
        .chan_i    (ch_q),
        .seq_i     (seq_q),
        .upd_i     (trk_upd),
        .seq_err_o (trk_err)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ch_d        = ch_q;
        seq_d       = seq_q;
        rec_valid_d = 1'b0;
        rec_ch_d    = '0;
        rec_bin_d   = '0;
        rec_data_d  = '0;
        done_d      = 1'b0;
        ok_d        = 1'b0;
        sync_d      = 1'b0;
        eseq_d      = 1'b0;
        ecsum_d     = 1'b0;
        trk_upd     = 1'b0;

        if (sink_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (hdr_sync == PR3_SYNC) begin
                        if (hdr_chan < NSINK_B) begin
                            ch_d    = hdr_chan[CHW-1:0];
                            seq_d   = sink_data[HDR_SEQ_LSB +: 16];
                            cnt_d   = '0;
                            acc_d   = '0;
                            state_d = PAYLOAD;
                        end else begin
                            sync_d = 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    // No resync here: a payload word that looks like a header is still data.
                    rec_valid_d = 1'b1;
                    rec_ch_d    = ch_q;
                    rec_bin_d   = cnt_q;
                    rec_data_d  = sink_data;
                    acc_d       = acc_q + sink_data;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIN) begin
                        state_d = TRAILER;
                    end
                end
                TRAILER: begin
                    done_d  = 1'b1;
                    eseq_d  = trk_err;
                    ecsum_d = (sink_data != acc_q);
                    ok_d    = !trk_err && (sink_data == acc_q);
                    trk_upd = 1'b1;
                    state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk40) begin
        if (reset) begin
            state_q        <= HUNT;
            cnt_q          <= '0;
            acc_q          <= '0;
            ch_q           <= '0;
            seq_q          <= '0;
            source_valid   <= 1'b0;
            source_channel <= '0;
            source_bin     <= '0;
            source_data    <= '0;
            frame_done     <= 1'b0;
            frame_ok       <= 1'b0;
            err_sync       <= 1'b0;
            err_seq        <= 1'b0;
            err_csum       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            ch_q           <= ch_d;
            seq_q          <= seq_d;
            source_valid   <= rec_valid_d;
            source_channel <= rec_ch_d;
            source_bin     <= rec_bin_d;
            source_data    <= rec_data_d;
            frame_done     <= done_d;
            frame_ok       <= ok_d;
            err_sync       <= sync_d;
            err_seq        <= eseq_d;
            err_csum       <= ecsum_d;
        end
    end

endmodule

// File: tb/tb_pr3_frame_decoder.sv
// Scoreboard bench for pr3_frame_decoder (FFT=4, NSINK=3): stimulus pushes the
// expected records and frame verdicts, a negedge monitor pops and compares them.
module tb_pr3_frame_decoder;

    localparam int NSINK = 3;
    localparam int FFT   = 4;
    localparam int NBIN  = 8;

    logic        clk40 = 1'b0;
    logic        reset;
    logic        sink_valid;
    logic [31:0] sink_data;
    logic        source_valid;
    logic [1:0]  source_channel;
    logic [2:0]  source_bin;
    logic [31:0] source_data;
    logic        frame_done, frame_ok, err_sync, err_seq, err_csum;

    always #5 clk40 = ~clk40;

    pr3_frame_decoder #(.NSINK(NSINK), .FFT(FFT)) dut (
        .clk40          (clk40),
        .reset          (reset),
        .sink_valid     (sink_valid),
        .sink_data      (sink_data),
        .source_valid   (source_valid),
        .source_channel (source_channel),
        .source_bin     (source_bin),
        .source_data    (source_data),
        .frame_done     (frame_done),
        .frame_ok       (frame_ok),
        .err_sync       (err_sync),
        .err_seq        (err_seq),
        .err_csum       (err_csum)
    );

    typedef struct {
        int          ch;
        int          bin;
        logic [31:0] data;
    } rec_t;

    rec_t       rec_q[$];
    logic [2:0] frm_q[$];      // {frame_ok, err_seq, err_csum}
    int         sync_pending;
    int         checks;
    int         errors;

    // Reference model state: last seq and seen flag per channel.
    int          last_seq [NSINK];
    bit          seen     [NSINK];
    logic [31:0] pl       [NBIN];

    rec_t       mon_r;
    logic [2:0] mon_f;

    always @(negedge clk40) begin
        if (source_valid) begin
            checks++;
            if (rec_q.size() == 0) begin
                errors++;
                $display("FAIL record: unexpected ch=%0d bin=%0d data=%h", source_channel, source_bin, source_data);
            end else begin
                mon_r = rec_q.pop_front();
                if (int'(source_channel) != mon_r.ch || int'(source_bin) != mon_r.bin || source_data != mon_r.data) begin
                    errors++;
                    $display("FAIL record: got ch=%0d bin=%0d data=%h, want ch=%0d bin=%0d data=%h",
                             source_channel, source_bin, source_data, mon_r.ch, mon_r.bin, mon_r.data);
                end
            end
        end
        if (frame_done) begin
            checks++;
            if (frm_q.size() == 0) begin
                errors++;
                $display("FAIL frame: unexpected frame_done ok/seq/csum=%b", {frame_ok, err_seq, err_csum});
            end else begin
                mon_f = frm_q.pop_front();
                $display("frame: ok/seq/csum got %b want %b", {frame_ok, err_seq, err_csum}, mon_f);
                if ({frame_ok, err_seq, err_csum} != mon_f) begin
                    errors++;
                    $display("FAIL frame: ok/seq/csum got %b want %b", {frame_ok, err_seq, err_csum}, mon_f);
                end
            end
        end
        if (err_sync) begin
            checks++;
            $display("sync error pulse");
            if (sync_pending == 0) begin
                errors++;
                $display("FAIL err_sync: unexpected pulse, got 1 want 0");
            end else begin
                sync_pending--;
            end
        end
    end

    task automatic idle();
        sink_valid = 1'b0;
        sink_data  = $urandom;
        @(posedge clk40);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input int maxgap);
        repeat ($urandom_range(0, maxgap)) idle();
        sink_valid = 1'b1;
        sink_data  = w;
        @(posedge clk40);
        #1;
        sink_valid = 1'b0;
        sink_data  = $urandom;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        sink_valid = 1'b0;
        repeat (2) @(posedge clk40);
        #1;
        reset = 1'b0;
        for (int c = 0; c < NSINK; c++) begin
            seen[c]     = 1'b0;
            last_seq[c] = 0;
        end
    endtask

    // Sends a complete frame from pl[]; trailer = payload sum + csum_delta.
    task automatic frame(input int ch, input int seq, input logic [31:0] csum_delta, input int maxgap);
        logic [31:0] sum;
        bit          e_seq, e_csum;
        sum = '0;
        for (int i = 0; i < NBIN; i++) begin
            rec_q.push_back('{ch: ch, bin: i, data: pl[i]});
            sum += pl[i];
        end
        e_seq  = seen[ch] && (((last_seq[ch] + 1) % 65536) != seq);
        e_csum = (csum_delta != 0);
        frm_q.push_back({!(e_seq || e_csum), e_seq, e_csum});
        seen[ch]     = 1'b1;
        last_seq[ch] = seq;
        send({8'hA5, 8'(ch), 16'(seq)}, maxgap);
        for (int i = 0; i < NBIN; i++) send(pl[i], maxgap);
        send(sum + csum_delta, maxgap);
    endtask

    task automatic ramp_payload();
        for (int i = 0; i < NBIN; i++) pl[i] = 32'(i + 1);
    endtask

    task automatic rand_payload();
        for (int i = 0; i < NBIN; i++) begin
            pl[i] = $urandom;
            if ($urandom_range(0, 4) == 0) pl[i][31:24] = 8'hA5;
        end
    endtask

    initial begin
        int ch, seq, mg;
        logic [31:0] delta, noise;
        checks = 0;
        errors = 0;
        sync_pending = 0;
        sink_valid = 1'b0;
        sink_data  = '0;
        do_reset();

        checks++;
        if ({source_valid, source_channel, source_bin, source_data, frame_done, frame_ok, err_sync, err_seq, err_csum} != '0) begin
            errors++;
            $display("FAIL reset: outputs got nonzero want all 0 (valid=%b done=%b ok=%b)", source_valid, frame_done, frame_ok);
        end

        // Basic good frame, then checksum error (seq follows so only csum trips).
        ramp_payload();
        frame(1, 7, 32'd0, 0);
        frame(1, 8, 32'd1, 0);

        // Sequence gap on channel 0, then recovery.
        frame(0, 5, 32'd0, 0);
        frame(0, 7, 32'd0, 0);
        frame(0, 8, 32'd0, 0);

        // Out-of-range channel header, then a normal frame.
        sync_pending++;
        send(32'hA503_0000, 0);
        frame(2, 100, 32'd0, 0);

        // Idle gaps plus a header-looking payload word.
        ramp_payload();
        pl[3] = 32'hA500_0000;
        frame(1, 9, 32'd0, 3);

        // Reset mid-frame after payload word 4: those records appear, no verdict.
        ramp_payload();
        send({8'hA5, 8'd1, 16'd50}, 0);
        for (int i = 0; i < 4; i++) begin
            rec_q.push_back('{ch: 1, bin: i, data: pl[i]});
            send(pl[i], 0);
        end
        do_reset();
        frame(1, 1234, 32'd0, 1);

        // Randomized traffic: noise in HUNT, bad headers, seq gaps, checksum errors.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                noise = $urandom;
                if (noise[31:24] == 8'hA5) noise[31:24] = 8'h5A;
                send(noise, 1);
            end
            if ($urandom_range(0, 5) == 0) begin
                sync_pending++;
                send({8'hA5, 8'($urandom_range(3, 255)), 16'($urandom)}, 1);
            end
            ch  = $urandom_range(0, NSINK - 1);
            seq = ($urandom_range(0, 3) != 0) ? ((last_seq[ch] + 1) % 65536) : int'($urandom_range(0, 65535));
            delta = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 1000)) : 32'd0;
            mg = $urandom_range(0, 2);
            rand_payload();
            frame(ch, seq, delta, mg);
        end

        repeat (5) idle();
        checks++;
        if (rec_q.size() != 0 || frm_q.size() != 0 || sync_pending != 0) begin
            errors++;
            $display("FAIL drain: leftover records=%0d frames=%0d syncs=%0d, want 0/0/0", rec_q.size(), frm_q.size(), sync_pending);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
